// File: rtl/slc3_mem_pkg.sv
// slc3_mem_pkg
// Shared types and constants for the SLC-3 memory-port scheduler.
//   state_t     : scheduler FSM states
//   grant_t     : arbiter result (nobody / loader / CPU)
//   IO_ADDR_DEF : default address of the memory-mapped switch/hex word
//   SW_W        : width of the board switch bus, zero-extended on IO reads
package slc3_mem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      WR,
      IO,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_LD,
      GNT_CPU
   } grant_t;

   localparam logic [15:0] IO_ADDR_DEF = 16'hFFFF;
   localparam int          SW_W        = 10;

endpackage

// File: rtl/slc3_mem_arb.sv
// slc3_mem_arb
// Two-requester arbiter for the SLC-3 memory port.
// Build option: SLC3_MEM_SCHED_RR_EN selects round-robin tie breaking;
// without it the loader always wins a tie.
// Ports:
//   Clk, Reset_n : clock and asynchronous active-low reset
//   ld_req       : loader request
//   cpu_req      : CPU request
//   take         : scheduler is idle and will accept the grant this edge
//   gnt          : combinational grant (GNT_NONE / GNT_LD / GNT_CPU)
module slc3_mem_arb
   import slc3_mem_pkg::*;
(
   input  logic   Clk,
   input  logic   Reset_n,
   input  logic   ld_req,
   input  logic   cpu_req,
   input  logic   take,
   output grant_t gnt
);

`ifdef SLC3_MEM_SCHED_RR_EN
   // Remembers who was granted last; starts as CPU so the loader wins the
   // first tie after reset.
   logic last_cpu;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         last_cpu <= 1'b1;
      end else if (take && gnt != GNT_NONE) begin
         last_cpu <= (gnt == GNT_CPU);
      end
   end

   always_comb begin
      gnt = GNT_NONE;
      if (ld_req && cpu_req) begin
         gnt = last_cpu ? GNT_LD : GNT_CPU;
      end else if (ld_req) begin
         gnt = GNT_LD;
      end else if (cpu_req) begin
         gnt = GNT_CPU;
      end
   end
`else
   // Fixed priority needs no history, so the clock, reset and take inputs
   // have no work to do in this build.
   logic unused_fixed_prio;
   assign unused_fixed_prio = ^{Clk, Reset_n, take};

   always_comb begin
      gnt = GNT_NONE;
      if (ld_req) begin
         gnt = GNT_LD;
      end else if (cpu_req) begin
         gnt = GNT_CPU;
      end
   end
`endif

endmodule

// File: rtl/slc3_mem_sched.sv
// slc3_mem_sched
// Memory-port scheduler for the SLC-3: shares the single SRAM port between
// the program loader and the CPU datapath, and decodes the memory-mapped
// switch/hex word at IO_ADDR. All outputs are registered.
// Build option: SLC3_MEM_SCHED_RR_EN (round-robin tie breaking, see slc3_mem_arb).
// Ports:
//   Clk, Reset_n                          : clock, asynchronous active-low reset
//   ld_req/ld_we/ld_addr/ld_wdata, ld_ack : loader request channel
//   cpu_req/cpu_we/cpu_addr/cpu_wdata     : CPU request channel
//   cpu_rdata, cpu_ack                    : CPU read data and completion pulse
//   sram_addr/wdata/rdata, sram_*_n       : SRAM port (active-low strobes)
//   sw                                    : board switches (IO reads)
//   hex_data                              : latched hex-display value (IO writes)
module slc3_mem_sched
   import slc3_mem_pkg::*;
#(
   parameter int                ADDR_W  = 16,
   parameter int                DATA_W  = 16,
   parameter int                RD_LAT  = 2,
   parameter logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(IO_ADDR_DEF)
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_ack,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   input  logic [SW_W-1:0]   sw,
   output logic [DATA_W-1:0] hex_data
);

   state_t            state, next_state;
   grant_t            win, gnt_q;
   logic              we_q;
   logic [2:0]        cnt;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic [DATA_W-1:0] sw_ext;

   assign sw_ext = {{(DATA_W-SW_W){1'b0}}, sw};

   slc3_mem_arb u_arb (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .ld_req  (ld_req),
      .cpu_req (cpu_req),
      .take    (state == IDLE),
      .gnt     (win)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Winner's request fields and next-state decode. The IO word always
   // takes the IO path, even for what would otherwise be an SRAM access.
   always_comb begin
      win_we     = ld_we;
      win_addr   = ld_addr;
      win_wdata  = ld_wdata;
      next_state = state;
      if (win == GNT_CPU) begin
         win_we    = cpu_we;
         win_addr  = cpu_addr;
         win_wdata = cpu_wdata;
      end
      case (state)
         IDLE: begin
            if (win != GNT_NONE) begin
               if (win_addr == IO_ADDR) begin
                  next_state = IO;
               end else if (win_we) begin
                  next_state = WR;
               end else begin
                  next_state = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            if (cnt == 3'(RD_LAT - 1)) begin
               next_state = DONE;
            end
         end
         WR:      next_state = DONE;
         IO:      next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs are registered from the next state so the strobes and acks
   // line up exactly with the state they belong to.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         gnt_q      <= GNT_NONE;
         we_q       <= 1'b0;
         cnt        <= 3'd0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
         ld_ack     <= 1'b0;
         cpu_ack    <= 1'b0;
         cpu_rdata  <= '0;
         hex_data   <= '0;
      end else begin
         sram_ce_n <= !(next_state == RD_WAIT || next_state == WR);
         sram_oe_n <= !(next_state == RD_WAIT);
         sram_we_n <= !(next_state == WR);
         ld_ack    <= (next_state == DONE) && (gnt_q == GNT_LD);
         cpu_ack   <= (next_state == DONE) && (gnt_q == GNT_CPU);
         cnt       <= (state == RD_WAIT && next_state == RD_WAIT) ? cnt + 3'd1 : 3'd0;

         if (state == IDLE && win != GNT_NONE) begin
            gnt_q      <= win;
            we_q       <= win_we;
            sram_addr  <= win_addr;
            sram_wdata <= win_wdata;
         end

         // Loader reads complete but have nowhere to put their data.
         if (state == RD_WAIT && next_state == DONE && gnt_q == GNT_CPU) begin
            cpu_rdata <= sram_rdata;
         end

         if (state == IO) begin
            if (we_q) begin
               hex_data <= sram_wdata;
            end else if (gnt_q == GNT_CPU) begin
               cpu_rdata <= sw_ext;
            end
         end
      end
   end

endmodule

// File: tb/tb_slc3_mem_sched.sv
// tb_slc3_mem_sched
// Self-checking bench for slc3_mem_sched: directed transactions, a reset
// abort, simultaneous loader/CPU streams and a randomized phase. Expected
// responses come from a transaction-level memory/IO model and are queued
// at issue time; a monitor pops one entry per ack.
module tb_slc3_mem_sched;

   localparam int          RD_LAT = 2;
   localparam logic [15:0] IO_A   = 16'hFFFF;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b1;
   logic        ld_req = 1'b0, ld_we = 1'b0;
   logic [15:0] ld_addr = '0, ld_wdata = '0;
   logic        ld_ack;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [15:0] cpu_addr = '0, cpu_wdata = '0;
   logic [15:0] cpu_rdata;
   logic        cpu_ack;
   logic [15:0] sram_addr, sram_wdata;
   logic [15:0] sram_rdata = '0;
   logic        sram_ce_n, sram_oe_n, sram_we_n;
   logic [9:0]  sw = '0;
   logic [15:0] hex_data;

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   slc3_mem_sched #(.RD_LAT(RD_LAT)) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .ld_req     (ld_req),
      .ld_we      (ld_we),
      .ld_addr    (ld_addr),
      .ld_wdata   (ld_wdata),
      .ld_ack     (ld_ack),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_ack    (cpu_ack),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .sram_ce_n  (sram_ce_n),
      .sram_oe_n  (sram_oe_n),
      .sram_we_n  (sram_we_n),
      .sw         (sw),
      .hex_data   (hex_data)
   );

   // ---------------- SRAM environment model ----------------
   logic [15:0] sram_mem [logic [15:0]];

   function automatic logic [15:0] default_word(logic [15:0] a);
      return a ^ 16'hC3A5;
   endfunction

   function automatic logic [15:0] sram_read(logic [15:0] a);
      return sram_mem.exists(a) ? sram_mem[a] : default_word(a);
   endfunction

   always @(negedge Clk) begin
      sram_rdata <= (!sram_ce_n && !sram_oe_n) ? sram_read(sram_addr) : 16'hDEAD;
      if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr] = sram_wdata;
   end

   // ---------------- Check bookkeeping ----------------
   int checks = 0;
   int passes = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
   endtask

   task automatic fail_now(string name);
      checks++;
      $display("[TB] FAIL %s: event did not occur within its bound (cycle %0d)", name, cyc);
   endtask

   // ---------------- Reference model ----------------
   typedef struct {
      bit          who_cpu;
      logic [15:0] rdata;
      logic [15:0] hex;
      logic [15:0] addr;
      int          ack_cyc;
      int          rd_strb;
      int          wr_strb;
   } exp_t;

   exp_t        expq[$];
   logic [15:0] ref_mem [logic [15:0]];
   logic [15:0] m_hex = '0;
   logic [15:0] m_rdata = '0;
   bit          m_last_cpu = 1'b1;

   function automatic logic [15:0] ref_read(logic [15:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : default_word(a);
   endfunction

   function automatic exp_t predict(bit who_cpu, bit we, logic [15:0] addr,
                                    logic [15:0] wdata, int ack_cyc);
      exp_t e;
      e.who_cpu = who_cpu;
      e.addr    = addr;
      e.ack_cyc = ack_cyc;
      e.rd_strb = 0;
      e.wr_strb = 0;
      if (addr == IO_A) begin
         if (we) m_hex = wdata;
         else if (who_cpu) m_rdata = {6'b0, sw};
      end else if (we) begin
         ref_mem[addr] = wdata;
         e.wr_strb = 1;
      end else begin
         e.rd_strb = RD_LAT;
         if (who_cpu) m_rdata = ref_read(addr);
      end
      e.rdata    = m_rdata;
      e.hex      = m_hex;
      m_last_cpu = who_cpu;
      return e;
   endfunction

   // ---------------- Monitor ----------------
   int rd_cnt = 0, wr_cnt = 0, bad_cnt = 0;

   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         if (!Reset_n) begin
            rd_cnt = 0; wr_cnt = 0; bad_cnt = 0;
            continue;
         end
         if (!sram_ce_n && !sram_oe_n) rd_cnt++;
         if (!sram_ce_n && !sram_we_n) wr_cnt++;
         if ((!sram_we_n && !sram_oe_n) || (sram_ce_n && (!sram_we_n || !sram_oe_n))) bad_cnt++;
         if (ld_ack || cpu_ack) begin
            if (expq.size() == 0) begin
               fail_now("unexpected_ack");
            end else begin
               e = expq.pop_front();
               check("ack_who", {30'b0, ld_ack, cpu_ack}, e.who_cpu ? 32'd1 : 32'd2);
               check("cpu_rdata", cpu_rdata, e.rdata);
               check("hex_data", hex_data, e.hex);
               check("sram_addr", sram_addr, e.addr);
               if (e.ack_cyc >= 0) check("ack_cycle", cyc, e.ack_cyc);
               check("read_strobe_cycles", rd_cnt, e.rd_strb);
               check("write_strobe_cycles", wr_cnt, e.wr_strb);
               check("strobe_conflicts", bad_cnt, 0);
            end
            rd_cnt = 0; wr_cnt = 0; bad_cnt = 0;
         end
      end
   end

   // ---------------- Drivers ----------------
   task automatic drive(bit who_cpu, bit req, bit we, logic [15:0] addr, logic [15:0] wdata);
      if (who_cpu) begin
         cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      end else begin
         ld_req = req; ld_we = we; ld_addr = addr; ld_wdata = wdata;
      end
   endtask

   // Returns #1 after the edge that ends the ack cycle (the IDLE cycle).
   task automatic wait_own_ack(bit who_cpu, int limit);
      int n = 0;
      do begin
         @(negedge Clk);
         n++;
      end while (!(who_cpu ? cpu_ack : ld_ack) && n < limit);
      if (!(who_cpu ? cpu_ack : ld_ack)) fail_now(who_cpu ? "cpu_ack_timeout" : "ld_ack_timeout");
      @(posedge Clk); #1;
   endtask

   task automatic applyStimulus(bit who_cpu, bit we, logic [15:0] addr, logic [15:0] wdata);
      int lat;
      @(posedge Clk); #1;
      lat = (addr == IO_A || we) ? 2 : 1 + RD_LAT;
      expq.push_back(predict(who_cpu, we, addr, wdata, cyc + lat));
      drive(who_cpu, 1'b1, we, addr, wdata);
      wait_own_ack(who_cpu, 40);
      drive(who_cpu, 1'b0, we, addr, wdata);
   endtask

   logic [15:0] ld_addrs [3];
   logic [15:0] ld_vals  [3];
   logic [15:0] cpu_addrs[3];

   task automatic stream(bit who_cpu);
      @(posedge Clk); #1;
      for (int i = 0; i < 3; i++) begin
         if (who_cpu) drive(1'b1, 1'b1, 1'b0, cpu_addrs[i], 16'h0);
         else         drive(1'b0, 1'b1, 1'b1, ld_addrs[i], ld_vals[i]);
         wait_own_ack(who_cpu, 100);
      end
      drive(who_cpu, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   // Predicts the grant order for two 3-deep streams raised together.
   task automatic predict_contention();
      int  nl = 3, nc = 3, il = 0, ic = 0;
      bit  pick_cpu;
      while (nl > 0 || nc > 0) begin
         if (nl > 0 && nc > 0) begin
`ifdef SLC3_MEM_SCHED_RR_EN
            pick_cpu = !m_last_cpu;
`else
            pick_cpu = 1'b0;
`endif
         end else begin
            pick_cpu = (nc > 0);
         end
         if (pick_cpu) begin
            expq.push_back(predict(1'b1, 1'b0, cpu_addrs[ic], 16'h0, -1));
            ic++; nc--;
         end else begin
            expq.push_back(predict(1'b0, 1'b1, ld_addrs[il], ld_vals[il], -1));
            il++; nl--;
         end
      end
   endtask

   task automatic checkOutput(string tag);
      check({tag, "_ce_n"}, sram_ce_n, 1);
      check({tag, "_oe_n"}, sram_oe_n, 1);
      check({tag, "_we_n"}, sram_we_n, 1);
      check({tag, "_ld_ack"}, ld_ack, 0);
      check({tag, "_cpu_ack"}, cpu_ack, 0);
      check({tag, "_cpu_rdata"}, cpu_rdata, m_rdata);
      check({tag, "_hex_data"}, hex_data, m_hex);
   endtask

   task automatic model_reset();
      m_hex = '0;
      m_rdata = '0;
      m_last_cpu = 1'b1;
   endtask

   // ---------------- Main sequence ----------------
   initial begin
      #1 Reset_n = 1'b0;
      #1;
      model_reset();
      checkOutput("reset");
      check("reset_sram_addr", sram_addr, 0);
      check("reset_sram_wdata", sram_wdata, 0);
      #20 Reset_n = 1'b1;

      $display("[TB] directed SRAM read");
      sram_mem[16'h0010] = 16'h1234;
      ref_mem[16'h0010]  = 16'h1234;
      applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0);

      $display("[TB] loader write then CPU read");
      applyStimulus(1'b0, 1'b1, 16'h0200, 16'hABCD);
      applyStimulus(1'b1, 1'b0, 16'h0200, 16'h0);

      $display("[TB] IO word");
      sw = 10'h00B;
      applyStimulus(1'b1, 1'b0, IO_A, 16'h0);
      applyStimulus(1'b1, 1'b1, IO_A, 16'h00C5);

      $display("[TB] address just below IO word");
      applyStimulus(1'b0, 1'b1, 16'hFFFE, 16'h5AA5);
      applyStimulus(1'b1, 1'b0, 16'hFFFE, 16'h0);

      $display("[TB] reset during read wait");
      @(posedge Clk); #1;
      drive(1'b1, 1'b1, 1'b0, 16'h0200, 16'h0);
      @(posedge Clk); #3;
      check("in_rd_wait_oe_n", sram_oe_n, 0);
      Reset_n = 1'b0;
      #1;
      model_reset();
      checkOutput("abort");
      drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
      repeat (2) @(negedge Clk);
      #2 Reset_n = 1'b1;
      applyStimulus(1'b1, 1'b0, 16'h0200, 16'h0);

      $display("[TB] simultaneous loader and CPU streams");
      for (int i = 0; i < 3; i++) begin
         ld_addrs[i]  = 16'h0300 + 16'(i);
         ld_vals[i]   = 16'($urandom);
         cpu_addrs[i] = 16'h0302 - 16'(i);
      end
      predict_contention();
      fork
         stream(1'b0);
         stream(1'b1);
      join

      $display("[TB] randomized transactions");
      for (int t = 0; t < 40; t++) begin
         int          pick;
         logic [15:0] a;
         pick = int'($urandom_range(0, 9));
         a = (pick == 9) ? IO_A : (pick == 8) ? 16'hFFFE : 16'h0010 + 16'(pick);
         sw = 10'($urandom);
         applyStimulus(1'($urandom), 1'($urandom), a, 16'($urandom));
      end

      repeat (5) @(negedge Clk);
      check("queue_drained", expq.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
